uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

Receive half of the debug-unit UART link: a 16x-oversampling asynchronous serial receiver with an integrated baud-tick generator. It sits directly upstream of the debug unit. It deserialises 8N1 frames from the external host line and presents each byte with a one-cycle done strobe. The debug unit consumes that byte as a command or program data. Framing errors and start-bit glitches are rejected, never forwarded.

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: oversample ticks spent in the stop bit (16 = 1 stop bit).
- `BAUD_DIV`, 163: clock cycles per oversample tick (50 MHz / (19200·16)); legal range ≥ 2.
- `i_clock` in 1: system clock, all logic on rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_rx` in 1: serial line, idle high, asynchronous to `i_clock`.
- `o_rx_data` out `DBIT`: last correctly received byte; holds until next good frame.
- `o_rx_done_tick` out 1: one-cycle pulse, `o_rx_data` valid from the same cycle.
- `o_frame_error` out 1: one-cycle pulse when the stop-bit sample is 0.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- Input synchroniser: 2 flip-flops on `i_rx`, both reset to 1. All FSM decisions use the synchronised bit `rx_s`.
- Tick generator: free-running counter 0..`BAUD_DIV`-1, reset 0. `tick` is high for the one cycle when the counter equals `BAUD_DIV`-1. The counter wraps to 0 and never stops or resynchronises.
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE, with `s_cnt`=0, `n_cnt`=0 and shift register 0.
- IDLE:
  - `rx_s`==0 → START, `s_cnt`←0. The transition is taken on any cycle, not only on a tick.
- START, on tick:
  - If `s_cnt`==7 (mid start bit) and `rx_s`==1 → IDLE. This is a glitch: no output and no error.
  - If `s_cnt`==7 and `rx_s`==0 → DATA, `s_cnt`←0, `n_cnt`←0.
  - Otherwise `s_cnt`++.
- DATA, on tick:
  - If `s_cnt`==15, shift right with `rx_s` into the MSB and set `s_cnt`←0.
  - Then, if `n_cnt`==`DBIT`-1 → STOP, otherwise `n_cnt`++.
  - Otherwise `s_cnt`++.
- STOP, on tick:
  - If `s_cnt`==`SB_TICK`-1 and `rx_s`==1: `o_rx_data`←shift register, pulse `o_rx_done_tick`, → IDLE.
  - If `s_cnt`==`SB_TICK`-1 and `rx_s`==0: pulse `o_frame_error`, leave `o_rx_data` unchanged, → IDLE.
  - Otherwise `s_cnt`++.
- After a frame error the FSM returns to IDLE. It treats a still-low line as a new start bit; this is required behaviour and resynchronises on the next falling edge.
- `o_rx_done_tick` and `o_frame_error` are never high in the same cycle.
- Counter widths: `s_cnt` 4 bits minimum (must hold `SB_TICK`-1); `n_cnt` = clog2(`DBIT`).

## Timing
- Reset values: `o_rx_data`=0, `o_rx_done_tick`=0, `o_frame_error`=0, `o_busy`=0.
- Reset is honoured in any state, including mid-frame. The FSM returns to IDLE immediately and the partial byte is discarded without a pulse.
- Outputs are registered. `o_rx_done_tick` / `o_frame_error` rise in the cycle after the tick on which the stop sample is taken, and stay high exactly one cycle.
- Sample points, counted from the first cycle `rx_s`==0:
  - Start bit checked at about 8 ticks.
  - Data bit k sampled at about 8+16·(k+1) ticks.
  - Stop bit sampled at about 8+16·`DBIT`+`SB_TICK` ticks.
  - The first-tick phase uncertainty is ≤ 1 tick, plus 2 cycles of synchroniser delay.
- Frame-to-frame: back-to-back frames (a stop bit followed immediately by the next start bit) must be received with no loss.
- `o_busy` falls in the same cycle the done or error pulse rises.

## Test plan
Use `BAUD_DIV`=4, so one bit = 64 cycles.
- Reset then idle line: hold `i_rx`=1 for 2000 cycles → all outputs 0, no pulses.
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) → exactly one `o_rx_done_tick`, `o_rx_data`=0xA5, about 9.5 bit times after the falling edge. `o_frame_error` stays 0.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap → three done pulses, with data 0x00, 0xFF, 0x3C in order.
- Glitch: `i_rx` low for 12 cycles, then high → no pulse, FSM back in IDLE. A following 0x5A frame is received correctly.
- Framing error: send 0x81 with the stop bit driven 0 → one `o_frame_error` pulse, no done pulse, `o_rx_data` keeps its previous value.
- Reset mid-frame: assert `i_reset` during data bit 4 of 0xC3, release it, then send 0x12 → no pulse for the aborted frame, then one done pulse with data 0x12.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampling 8N1 UART receiver with an integrated baud-tick generator.
// Bytes are delivered with a one-cycle done strobe; bad stop bits raise a
// one-cycle frame-error strobe instead, and start-bit glitches are ignored.
module uart_rx_oversampled #(
    parameter int DBIT     = 8,   // data bits per frame, LSB first
    parameter int SB_TICK  = 16,  // oversample ticks spent in the stop bit
    parameter int BAUD_DIV = 163  // clock cycles per oversample tick (>= 2)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_rx_data,
    output logic            o_rx_done_tick,
    output logic            o_frame_error,
    output logic            o_busy
);

    localparam int B_W  = $clog2(BAUD_DIV);
    localparam int S_W  = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // Two-flop synchroniser; both stages reset to the idle (high) level so
    // reset release never looks like a start bit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both stages sample the
            // pre-edge values, giving a real two-stage pipeline.
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Baud-tick generator: free-running, never resynchronised to the line
    // ------------------------------------------------------------------
    logic [B_W-1:0] baud_cnt_q;
    logic [B_W-1:0] baud_cnt_d;
    logic           tick;

    assign tick = (baud_cnt_q == B_W'(BAUD_DIV - 1));

    // Next count: wrap to zero on the tick cycle.
    always_comb begin
        baud_cnt_d = baud_cnt_q + B_W'(1);
        if (tick) begin
            baud_cnt_d = '0;
        end
    end

    // Tick counter register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM with registered outputs
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [S_W-1:0]  s_cnt_q;
    logic [N_W-1:0]  n_cnt_q;
    logic [DBIT-1:0] shift_q;
    logic [DBIT-1:0] rx_data_q;
    logic            done_q;
    logic            err_q;
    logic            busy_q;

    // Frame sequencing, sampling and output strobes in one registered block.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // Strobes are one cycle wide unless re-asserted below.
            done_q <= 1'b0;
            err_q  <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    // Falling edge detection runs every cycle, not only on ticks.
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        s_cnt_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (s_cnt_q == S_W'(7)) begin
                            if (rx_s_q) begin
                                // Line went back high mid start bit: glitch.
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_DATA;
                                s_cnt_q <= '0;
                                n_cnt_q <= '0;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + S_W'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        if (s_cnt_q == S_W'(15)) begin
                            shift_q <= {rx_s_q, shift_q[DBIT-1:1]};
                            s_cnt_q <= '0;
                            if (n_cnt_q == N_W'(DBIT - 1)) begin
                                state_q <= S_STOP;
                            end else begin
                                n_cnt_q <= n_cnt_q + N_W'(1);
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + S_W'(1);
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        if (s_cnt_q == S_W'(SB_TICK - 1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            if (rx_s_q) begin
                                rx_data_q <= shift_q;
                                done_q    <= 1'b1;
                            end else begin
                                // Bad stop bit: keep the last good byte.
                                err_q <= 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + S_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx_data      = rx_data_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_error  = err_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed testbench for uart_rx_oversampled with BAUD_DIV=4 (64 cycles/bit).
module tb_uart_rx_oversampled;

    localparam int BIT_CYC = 64;

    logic       i_clock;
    logic       i_reset;
    logic       i_rx;
    logic [7:0] o_rx_data;
    logic       o_rx_done_tick;
    logic       o_frame_error;
    logic       o_busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor state
    int         cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] data_q[$];
    logic       busy_at_done = 1'b1;
    logic       prev_busy_at_done = 1'b0;
    logic       busy_at_err = 1'b1;
    logic       both_seen = 1'b0;
    logic       wide_seen = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;
    logic       prev_busy = 1'b0;
    int         t_fall = 0;
    int         lat = 0;

    uart_rx_oversampled #(
        .DBIT(8),
        .SB_TICK(16),
        .BAUD_DIV(4)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_rx(i_rx),
        .o_rx_data(o_rx_data),
        .o_rx_done_tick(o_rx_done_tick),
        .o_frame_error(o_frame_error),
        .o_busy(o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) cyc <= cyc + 1;

    // Observe strobes on the falling edge, away from the active edge.
    always @(negedge i_clock) begin
        if (!i_reset) begin
            if (o_rx_done_tick) begin
                done_cnt++;
                data_q.push_back(o_rx_data);
                done_cyc = cyc;
                busy_at_done = o_busy;
                prev_busy_at_done = prev_busy;
            end
            if (o_frame_error) begin
                err_cnt++;
                busy_at_err = o_busy;
            end
            if (o_rx_done_tick && o_frame_error) both_seen = 1'b1;
            if ((o_rx_done_tick && prev_done) || (o_frame_error && prev_err)) wide_seen = 1'b1;
        end
        prev_done = o_rx_done_tick;
        prev_err  = o_frame_error;
        prev_busy = o_busy;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic send_bit(input logic v);
        i_rx = v;
        wait_cycles(BIT_CYC);
    endtask

    // Start bit plus data bits, LSB first; caller drives the stop bit.
    task automatic send_head(input logic [7:0] b);
        t_fall = cyc;
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_head(b);
        send_bit(1'b1);
    endtask

    initial begin
        // Reset and idle line
        i_reset = 1'b1;
        i_rx    = 1'b1;
        wait_cycles(5);
        @(negedge i_clock);
        check("rst_data", {24'd0, o_rx_data}, 32'h00);
        check("rst_done", {31'd0, o_rx_done_tick}, 32'd0);
        check("rst_err",  {31'd0, o_frame_error}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        wait_cycles(1);
        i_reset = 1'b0;
        wait_cycles(2000);
        check("idle_done_cnt", done_cnt, 0);
        check("idle_err_cnt", err_cnt, 0);
        check("idle_data", {24'd0, o_rx_data}, 32'h00);
        check("idle_busy", {31'd0, o_busy}, 32'd0);

        // Single frame 0xA5; done expected ~609 cycles after the falling edge
        send_frame(8'hA5);
        wait_cycles(BIT_CYC);
        lat = done_cyc - t_fall;
        check("a5_done_cnt", done_cnt, 1);
        check("a5_data", {24'd0, o_rx_data}, 32'hA5);
        check("a5_err_cnt", err_cnt, 0);
        check("a5_latency_window", {31'd0, (lat >= 600 && lat <= 625)}, 32'd1);
        check("a5_busy_fall", {31'd0, busy_at_done}, 32'd0);
        check("a5_busy_before", {31'd0, prev_busy_at_done}, 32'd1);

        // Back-to-back frames, no idle gap
        send_frame(8'h00);
        send_frame(8'hFF);
        send_frame(8'h3C);
        wait_cycles(100);
        check("b2b_done_cnt", done_cnt, 4);
        if (data_q.size() == 4) begin
            check("b2b_data0", {24'd0, data_q[1]}, 32'h00);
            check("b2b_data1", {24'd0, data_q[2]}, 32'hFF);
            check("b2b_data2", {24'd0, data_q[3]}, 32'h3C);
        end else begin
            check("b2b_queue_size", data_q.size(), 4);
        end

        // Start-bit glitch: 12 cycles low
        i_rx = 1'b0;
        wait_cycles(12);
        i_rx = 1'b1;
        wait_cycles(100);
        check("glitch_done_cnt", done_cnt, 4);
        check("glitch_err_cnt", err_cnt, 0);
        check("glitch_busy", {31'd0, o_busy}, 32'd0);
        send_frame(8'h5A);
        wait_cycles(100);
        check("post_glitch_done_cnt", done_cnt, 5);
        check("post_glitch_data", {24'd0, o_rx_data}, 32'h5A);

        // Framing error: 0x81 with stop bit low long enough to be sampled,
        // then high before the re-armed start check falls due.
        send_head(8'h81);
        i_rx = 1'b0;
        wait_cycles(40);
        i_rx = 1'b1;
        wait_cycles(300);
        check("ferr_err_cnt", err_cnt, 1);
        check("ferr_done_cnt", done_cnt, 5);
        check("ferr_data_held", {24'd0, o_rx_data}, 32'h5A);
        check("ferr_busy_fall", {31'd0, busy_at_err}, 32'd0);
        check("ferr_busy_idle", {31'd0, o_busy}, 32'd0);

        // Reset during data bit 4 of 0xC3
        t_fall = cyc;
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(1'(8'hC3 >> k));
        i_rx = 1'b0;               // bit 4 of 0xC3 is 0
        wait_cycles(20);
        check("mid_busy_before_rst", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        i_rx = 1'b1;
        wait_cycles(3);
        @(negedge i_clock);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_data", {24'd0, o_rx_data}, 32'h00);
        wait_cycles(1);
        i_reset = 1'b0;
        wait_cycles(200);
        check("abort_done_cnt", done_cnt, 5);
        check("abort_err_cnt", err_cnt, 1);
        send_frame(8'h12);
        wait_cycles(100);
        check("post_rst_done_cnt", done_cnt, 6);
        check("post_rst_data", {24'd0, o_rx_data}, 32'h12);

        // Global strobe properties
        check("never_both_strobes", {31'd0, both_seen}, 32'd0);
        check("strobes_one_cycle", {31'd0, wide_seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
